// File: rtl/rgb_pwm_sequencer_pkg.sv
// Shared definitions for the RGB PWM sequencer: mode codes, fade FSM
// states, colour indices and the colour rotation helper.
package rgb_pwm_sequencer_pkg;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_STATIC = 2'd1,
    MODE_FADE   = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_FADE_UP   = 2'd1,
    ST_HOLD      = 2'd2,
    ST_FADE_DOWN = 2'd3
  } state_e;

  localparam logic [1:0] COL_R = 2'd0;
  localparam logic [1:0] COL_G = 2'd1;
  localparam logic [1:0] COL_B = 2'd2;

  // R -> G -> B -> R; an out-of-range index recovers to R.
  function automatic logic [1:0] next_colour(input logic [1:0] col);
    logic [1:0] nxt;
    case (col)
      COL_R:   nxt = COL_G;
      COL_G:   nxt = COL_B;
      COL_B:   nxt = COL_R;
      default: nxt = COL_R;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/rgb_pwm_sequencer_pwm_channel.sv
// One PWM channel: a shadow duty register reloaded only at the end of a
// PWM period, and a registered compare against the shared counter.
// Ports:
//   int_osc    clock
//   rst_n      async active-low reset
//   pwm_cnt    shared free-running period counter
//   period_end high on the last count of a period
//   target     requested duty, sampled at period_end
//   pwm_out    registered PWM enable
module rgb_pwm_sequencer_pwm_channel #(
  parameter int PWM_BITS = 8
) (
  input  logic                int_osc,
  input  logic                rst_n,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic                period_end,
  input  logic [PWM_BITS-1:0] target,
  output logic                pwm_out
);

  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic                pwm_out_q, pwm_out_d;

  // Shadow reload only at the period end so a running period is never cut short.
  always_comb begin
    duty_d    = duty_q;
    pwm_out_d = 1'b0;
    if (period_end) begin
      duty_d = target;
    end else begin
      duty_d = duty_q;
    end
    pwm_out_d = (pwm_cnt < duty_q);
  end

  // Duty and output registers.
  always_ff @(posedge int_osc or negedge rst_n) begin
    if (!rst_n) begin
      duty_q    <= {PWM_BITS{1'b0}};
      pwm_out_q <= 1'b0;
    end else begin
      duty_q    <= duty_d;
      pwm_out_q <= pwm_out_d;
    end
  end

  assign pwm_out = pwm_out_q;

endmodule

// File: rtl/rgb_pwm_sequencer.sv
// RGB PWM sequencer driving the RGB0/1/2PWM enables of the LED driver.
// Modes: off, static colour from static_rgb, or an R->G->B fade cycle
// (fade up, hold at full, fade down).
// Ports:
//   int_osc     clock (internal oscillator)
//   rst_n       async active-low reset
//   enable      1 = prescaler/fade advance, 0 = frozen (PWM keeps running)
//   mode        0 off, 1 static, 2 fade, 3 off
//   static_rgb  {r,g,b} duties used in static mode
//   pwm_r/g/b   PWM enables
//   step_tick   one-cycle pulse per brightness step
//   colour_idx  active fade colour (0 R, 1 G, 2 B)
module rgb_pwm_sequencer
  import rgb_pwm_sequencer_pkg::*;
#(
  parameter int PWM_BITS   = 8,
  parameter int STEP_DIV   = 46875,
  parameter int HOLD_STEPS = 256
) (
  input  logic                  int_osc,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [1:0]            mode,
  input  logic [3*PWM_BITS-1:0] static_rgb,
  output logic                  pwm_r,
  output logic                  pwm_g,
  output logic                  pwm_b,
  output logic                  step_tick,
  output logic [1:0]            colour_idx
);

  localparam int PRE_W  = $clog2(STEP_DIV + 1);
  localparam int HOLD_W = $clog2(HOLD_STEPS + 1);
  localparam logic [PWM_BITS-1:0] CNT_MAX   = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] LVL_ONE   = PWM_BITS'(1);
  localparam logic [PWM_BITS-1:0] LVL_TOP   = CNT_MAX - LVL_ONE;
  localparam logic [PRE_W-1:0]    PRE_LAST  = PRE_W'(STEP_DIV - 1);
  localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(HOLD_STEPS - 1);

  mode_e               mode_s;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PRE_W-1:0]    presc_q, presc_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [PWM_BITS-1:0] level_q, level_d;
  logic [1:0]          colour_q, colour_d;
  state_e              state_q, state_d;
  logic                period_end_s;
  logic                step_tick_s;
  logic [PWM_BITS-1:0] tgt_r_s, tgt_g_s, tgt_b_s;

  assign mode_s       = mode_e'(mode);
  assign pwm_cnt_d    = pwm_cnt_q + LVL_ONE;
  assign period_end_s = (pwm_cnt_q == CNT_MAX);
  assign step_tick_s  = enable & (presc_q == PRE_LAST);

  // Prescaler and fade FSM next-state; leaving fade mode parks everything in IDLE.
  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    hold_d   = hold_q;
    colour_d = colour_q;
    if (!enable) begin
      presc_d = presc_q;
    end else if (step_tick_s) begin
      presc_d = {PRE_W{1'b0}};
    end else begin
      presc_d = presc_q + PRE_W'(1);
    end

    if (mode_s != MODE_FADE) begin
      state_d  = ST_IDLE;
      level_d  = {PWM_BITS{1'b0}};
      hold_d   = {HOLD_W{1'b0}};
      colour_d = COL_R;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Every entry into fade mode restarts the cycle cleanly.
          state_d  = ST_FADE_UP;
          level_d  = {PWM_BITS{1'b0}};
          hold_d   = {HOLD_W{1'b0}};
          colour_d = COL_R;
          presc_d  = {PRE_W{1'b0}};
        end
        ST_FADE_UP: begin
          if (step_tick_s) begin
            level_d = level_q + LVL_ONE;
            if (level_q == LVL_TOP) begin
              state_d = ST_HOLD;
              hold_d  = {HOLD_W{1'b0}};
            end else begin
              state_d = ST_FADE_UP;
            end
          end else begin
            level_d = level_q;
          end
        end
        ST_HOLD: begin
          if (step_tick_s) begin
            if (hold_q == HOLD_LAST) begin
              state_d = ST_FADE_DOWN;
              hold_d  = {HOLD_W{1'b0}};
            end else begin
              hold_d = hold_q + HOLD_W'(1);
            end
          end else begin
            hold_d = hold_q;
          end
        end
        ST_FADE_DOWN: begin
          if (step_tick_s) begin
            level_d = level_q - LVL_ONE;
            // Reaching zero hands over to the next colour in the same cycle.
            if (level_q == LVL_ONE) begin
              colour_d = next_colour(colour_q);
              state_d  = ST_FADE_UP;
            end else begin
              state_d = ST_FADE_DOWN;
            end
          end else begin
            level_d = level_q;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Target duty per channel; applied by the channels at the next period end.
  always_comb begin
    tgt_r_s = {PWM_BITS{1'b0}};
    tgt_g_s = {PWM_BITS{1'b0}};
    tgt_b_s = {PWM_BITS{1'b0}};
    case (mode_s)
      MODE_STATIC: begin
        tgt_r_s = static_rgb[3*PWM_BITS-1 -: PWM_BITS];
        tgt_g_s = static_rgb[2*PWM_BITS-1 -: PWM_BITS];
        tgt_b_s = static_rgb[PWM_BITS-1:0];
      end
      MODE_FADE: begin
        case (colour_q)
          COL_R:   tgt_r_s = level_q;
          COL_G:   tgt_g_s = level_q;
          COL_B:   tgt_b_s = level_q;
          default: tgt_r_s = {PWM_BITS{1'b0}};
        endcase
      end
      default: begin
        tgt_r_s = {PWM_BITS{1'b0}};
      end
    endcase
  end

  // Counter, prescaler and FSM registers.
  always_ff @(posedge int_osc or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q <= {PWM_BITS{1'b0}};
      presc_q   <= {PRE_W{1'b0}};
      hold_q    <= {HOLD_W{1'b0}};
      level_q   <= {PWM_BITS{1'b0}};
      colour_q  <= COL_R;
      state_q   <= ST_IDLE;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      presc_q   <= presc_d;
      hold_q    <= hold_d;
      level_q   <= level_d;
      colour_q  <= colour_d;
      state_q   <= state_d;
    end
  end

  rgb_pwm_sequencer_pwm_channel #(.PWM_BITS(PWM_BITS)) u_ch_r (
    .int_osc(int_osc), .rst_n(rst_n), .pwm_cnt(pwm_cnt_q),
    .period_end(period_end_s), .target(tgt_r_s), .pwm_out(pwm_r)
  );

  rgb_pwm_sequencer_pwm_channel #(.PWM_BITS(PWM_BITS)) u_ch_g (
    .int_osc(int_osc), .rst_n(rst_n), .pwm_cnt(pwm_cnt_q),
    .period_end(period_end_s), .target(tgt_g_s), .pwm_out(pwm_g)
  );

  rgb_pwm_sequencer_pwm_channel #(.PWM_BITS(PWM_BITS)) u_ch_b (
    .int_osc(int_osc), .rst_n(rst_n), .pwm_cnt(pwm_cnt_q),
    .period_end(period_end_s), .target(tgt_b_s), .pwm_out(pwm_b)
  );

  assign step_tick  = step_tick_s;
  assign colour_idx = colour_q;

endmodule
